// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared constants for the register file and its write scoreboard
package regfile_sb_pkg;
    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;
    localparam int   RegBus      = 32;
    localparam int   RegAddrBus  = 5;
    localparam int   RegNum      = 32;
    localparam int   SbCntBus    = 2;
    localparam logic [RegBus-1:0] ZeroWord = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write counters, busy flags and sticky sb_err
// Optional same-cycle busy release on retire: REGFILE_BYPASS_EN
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_W = RegAddrBus,
    parameter int NREG   = RegNum,
    parameter int CNT_W  = SbCntBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              busy1,
    output logic              busy2,
    output logic              sb_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  inc_v;
    logic [NREG-1:0]  dec_v;
    logic             err_nxt;

    always_comb begin
        err_nxt = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
            inc_v[r]   = (r != 0) && issue_en && (issue_addr == ADDR_W'(r));
            dec_v[r]   = (r != 0) && (we == WriteEnable) && (waddr == ADDR_W'(r));
            // Simultaneous issue and retire cancel out with no error.
            if (inc_v[r] && !dec_v[r]) begin
                if (cnt[r] == CNT_MAX) err_nxt = 1'b1;
                else                   cnt_nxt[r] = cnt[r] + 1'b1;
            end else if (dec_v[r] && !inc_v[r]) begin
                if (cnt[r] == '0) err_nxt = 1'b1;
                else              cnt_nxt[r] = cnt[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
            if (err_nxt) sb_err <= 1'b1;
        end
    end

    function automatic logic port_busy(input logic re, input logic [ADDR_W-1:0] ra);
        logic b;
        b = (re == ReadEnable) && (ra != '0) && (cnt[ra] != '0);
`ifdef REGFILE_BYPASS_EN
        if (dec_v[ra] && !inc_v[ra] && (cnt[ra] == CNT_W'(1))) b = 1'b0;
`endif
        return b;
    endfunction

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (rst != RstEnable) begin
            busy1 = port_busy(re1, raddr1);
            busy2 = port_busy(re2, raddr2);
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 2R/1W register file with in-flight write scoreboard
// Optional write-to-read data bypass: REGFILE_BYPASS_EN
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus,
    parameter int NREG   = RegNum,
    parameter int CNT_W  = SbCntBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              sb_err
);
    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int r = 0; r < NREG; r++) mem[r] <= '0;
        end else if ((we == WriteEnable) && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    function automatic logic [DATA_W-1:0] port_read(input logic re, input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] d;
        d = '0;
        if ((re == ReadEnable) && (ra != '0)) begin
            d = mem[ra];
`ifdef REGFILE_BYPASS_EN
            if ((we == WriteEnable) && (waddr == ra)) d = wdata;
`endif
        end
        return d;
    endfunction

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rst != RstEnable) begin
            rdata1 = port_read(re1, raddr1);
            rdata2 = port_read(re2, raddr2);
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .we         (we),
        .waddr      (waddr),
        .re1        (re1),
        .raddr1     (raddr1),
        .re2        (re2),
        .raddr2     (raddr2),
        .busy1      (busy1),
        .busy2      (busy2),
        .sb_err     (sb_err)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst, we, re1, re2, issue_en;
    logic [4:0]  waddr, raddr1, raddr2, issue_addr;
    logic [31:0] wdata, rdata1, rdata2;
    logic        busy1, busy2, sb_err;

    int vectors = 0;
    int miscompares = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy1(busy1), .busy2(busy2), .sb_err(sb_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        issue_en = 1'b0; issue_addr = '0;
        tick(); tick();
        rst = 1'b0;
        #1;

        re1 = 1'b1; re2 = 1'b1;
        for (int r = 1; r < 32; r++) begin
            raddr1 = 5'(r); raddr2 = 5'(32 - r);
            #1;
            check("reset_rdata1", rdata1, 32'h0);
            check("reset_rdata2", rdata2, 32'h0);
            check("reset_busy1", {31'b0, busy1}, 32'h0);
            check("reset_busy2", {31'b0, busy2}, 32'h0);
        end
        check("reset_sb_err", {31'b0, sb_err}, 32'h0);

        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
        #1;
        check("r0_same_cycle", rdata1, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("r0_read", rdata1, 32'h0);
        check("r0_busy", {31'b0, busy1}, 32'h0);

        issue_en = 1'b1; issue_addr = 5'd5;
        tick();
        issue_en = 1'b0; raddr1 = 5'd5;
        #1;
        check("r5_busy_after_issue", {31'b0, busy1}, 32'h1);
        we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
        #1;
        check("r5_retire_rdata", rdata1, BYP ? 32'h1234_5678 : 32'h0);
        check("r5_retire_busy", {31'b0, busy1}, BYP ? 32'h0 : 32'h1);
        tick();
        we = 1'b0;
        #1;
        check("r5_after_rdata", rdata1, 32'h1234_5678);
        check("r5_after_busy", {31'b0, busy1}, 32'h0);
        re1 = 1'b0;
        #1;
        check("re1_low_rdata", rdata1, 32'h0);
        re1 = 1'b1;

        raddr2 = 5'd7;
        issue_en = 1'b1; issue_addr = 5'd7;
        tick(); tick(); tick();
        issue_en = 1'b0;
        #1;
        check("r7_busy_cnt3", {31'b0, busy2}, 32'h1);
        check("r7_no_err_yet", {31'b0, sb_err}, 32'h0);
        issue_en = 1'b1;
        tick();
        issue_en = 1'b0;
        #1;
        check("r7_overflow_err", {31'b0, sb_err}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            we = 1'b1; waddr = 5'd7; wdata = 32'h7000_0000 + k;
            tick();
            we = 1'b0;
            #1;
            check("r7_busy_retire", {31'b0, busy2}, (k < 2) ? 32'h1 : 32'h0);
        end
        check("r7_rdata", rdata2, 32'h7000_0002);
        check("r7_err_sticky", {31'b0, sb_err}, 32'h1);

        issue_en = 1'b1; issue_addr = 5'd4;
        we = 1'b1; waddr = 5'd4; wdata = 32'hDEAD_BEEF;
        tick();
        issue_en = 1'b0; we = 1'b0; raddr1 = 5'd4;
        #1;
        check("r4_pre_rst_rdata", rdata1, 32'hDEAD_BEEF);
        rst = 1'b1;
        we = 1'b1; waddr = 5'd6; wdata = 32'h6666_6666;
        #1;
        check("rst_forces_rdata", rdata1, 32'h0);
        check("rst_forces_busy", {31'b0, busy1}, 32'h0);
        tick();
        rst = 1'b0; we = 1'b0;
        #1;
        check("r4_post_rst_rdata", rdata1, 32'h0);
        check("r4_post_rst_busy", {31'b0, busy1}, 32'h0);
        check("post_rst_sb_err", {31'b0, sb_err}, 32'h0);
        raddr2 = 5'd6;
        #1;
        check("r6_write_in_rst_dropped", rdata2, 32'h0);
        raddr2 = 5'd5;
        #1;
        check("r5_cleared_by_rst", rdata2, 32'h0);

        issue_en = 1'b1; issue_addr = 5'd9;
        tick();
        raddr1 = 5'd9;
        we = 1'b1; waddr = 5'd9; wdata = 32'hCAFE_F00D;
        #1;
        check("r9_same_cycle_busy", {31'b0, busy1}, 32'h1);
        tick();
        issue_en = 1'b0; we = 1'b0;
        #1;
        check("r9_busy_held", {31'b0, busy1}, 32'h1);
        check("r9_rdata", rdata1, 32'hCAFE_F00D);
        check("r9_no_err", {31'b0, sb_err}, 32'h0);
        we = 1'b1; wdata = 32'h0909_0909;
        tick();
        we = 1'b0;
        #1;
        check("r9_busy_clear", {31'b0, busy1}, 32'h0);

        raddr1 = 5'd3;
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5;
        tick();
        we = 1'b0;
        #1;
        check("r3_underflow_err", {31'b0, sb_err}, 32'h1);
        check("r3_rdata", rdata1, 32'hA5A5_A5A5);
        check("r3_busy", {31'b0, busy1}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
